// File: rtl/surf_event_merger_if.sv
// Handshake bundle between the seven per-SURF byte streams and the merged event stream.
// master: the merger side (sinks s_*, sources m_*); slave: the environment side.
interface surf_event_merger_if #(
   parameter int NSURF = 7
);
   logic [8*NSURF-1:0] s_tdata;
   logic [NSURF-1:0]   s_tvalid;
   logic [NSURF-1:0]   s_tready;
   logic [NSURF-1:0]   s_tlast;
   logic [7:0]         m_tdata;
   logic               m_tvalid;
   logic               m_tready;
   logic               m_tlast;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/surf_event_merger.sv
// Merges one frame per enabled SURF, in ascending index, into one framed event with headers and tags.
// Optional XOR checksum trailer byte: define SURF_MERGER_CHECKSUM_EN.
module surf_event_merger #(
   parameter int         NSURF          = 7,
   parameter int         TIMEOUT_CYCLES = 4096,
   parameter logic [7:0] EVT_MAGIC      = 8'hEA
) (
   input  logic                 sysclk_i,
   input  logic                 rst_i,
   input  logic [NSURF-1:0]     enable_mask_i,
   surf_event_merger_if.master  bus,
   output logic [15:0]          event_count_o,
   output logic                 timeout_o,
   output logic                 busy_o
);
`ifdef SURF_MERGER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, WAIT, DATA, DONE, CSUM} state_t;

   state_t             state_q;
   logic [NSURF-1:0]   mask_q;
   logic [2:0]         sel_q;
   logic [TIMER_W-1:0] timer_q;
   logic [7:0]         csum_q;
   logic [7:0]         mData_q;
   logic               mValid_q;
   logic               mLast_q;
   logic               timeout_q;
   logic [15:0]        evtCount_q;

   logic       adv;
   logic       selValid;
   logic       selLast;
   logic [7:0] selData;
   logic       timerDone;
   logic       hasNext;
   logic       finalSurf;
   logic [2:0] firstSel;
   logic [2:0] nextSel;
   logic       emit_d;
   logic       last_d;
   logic [7:0] beat_d;

   assign adv       = !mValid_q || bus.m_tready;
   assign selValid  = bus.s_tvalid[sel_q];
   assign selLast   = bus.s_tlast[sel_q];
   assign selData   = bus.s_tdata[{sel_q, 3'b000} +: 8];
   assign timerDone = (timer_q == TIMER_MAX);
   assign finalSurf = !hasNext && !CSUM_EN;

   // Lowest enabled SURF to start an event, and the next enabled SURF above the current one.
   always_comb begin
      firstSel = '0;
      nextSel  = '0;
      hasNext  = 1'b0;
      for (int i = NSURF - 1; i >= 0; i--) begin
         if (enable_mask_i[i]) firstSel = 3'(i);
         if (mask_q[i] && (i > int'(sel_q))) begin
            nextSel = 3'(i);
            hasNext = 1'b1;
         end
      end
   end

   always_comb begin
      emit_d = 1'b0;
      last_d = 1'b0;
      beat_d = 8'h00;
      case (state_q)
         HDR0: begin emit_d = 1'b1; beat_d = EVT_MAGIC; end
         HDR1: begin emit_d = 1'b1; beat_d = evtCount_q[7:0]; end
         HDR2: begin emit_d = 1'b1; beat_d = 8'(mask_q); end
         WAIT: begin
            if (selValid) begin
               emit_d = 1'b1;
               beat_d = {4'h5, 1'b0, sel_q};
            end else if (timerDone) begin
               emit_d = 1'b1;
               beat_d = {4'h5, 1'b1, sel_q};
               last_d = finalSurf;
            end
         end
         DATA: begin
            emit_d = selValid;
            beat_d = selData;
            last_d = selLast && finalSurf;
         end
         CSUM: begin emit_d = 1'b1; beat_d = csum_q; last_d = 1'b1; end
         default: ;
      endcase
   end

   // Only the selected SURF is ever dequeued, and only when the output register can take the byte.
   always_comb begin
      bus.s_tready = '0;
      if (state_q == DATA) bus.s_tready[sel_q] = adv;
   end

   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         sel_q      <= '0;
         timer_q    <= '0;
         csum_q     <= '0;
         mData_q    <= '0;
         mValid_q   <= 1'b0;
         mLast_q    <= 1'b0;
         timeout_q  <= 1'b0;
         evtCount_q <= '0;
      end else begin
         timeout_q <= 1'b0;
         if (adv) mValid_q <= 1'b0;
         if (adv && emit_d) begin
            mValid_q <= 1'b1;
            mData_q  <= beat_d;
            mLast_q  <= last_d;
            csum_q   <= csum_q ^ beat_d;
         end
         case (state_q)
            IDLE: begin
               csum_q <= '0;
               if ((bus.s_tvalid & enable_mask_i) != '0) begin
                  mask_q  <= enable_mask_i;
                  sel_q   <= firstSel;
                  state_q <= HDR0;
               end
            end
            HDR0: if (adv) state_q <= HDR1;
            HDR1: if (adv) state_q <= HDR2;
            HDR2: if (adv) begin
               state_q <= WAIT;
               timer_q <= '0;
            end
            // The timer runs only while the SURF is silent; a stalled output never ages it.
            WAIT: begin
               if (selValid) begin
                  if (adv) state_q <= DATA;
               end else if (!timerDone) begin
                  timer_q <= timer_q + TIMER_W'(1);
               end else if (adv) begin
                  timeout_q <= 1'b1;
                  timer_q   <= '0;
                  if (hasNext) sel_q <= nextSel;
                  state_q <= hasNext ? WAIT : (CSUM_EN ? CSUM : DONE);
               end
            end
            DATA: if (adv && selValid && selLast) begin
               timer_q <= '0;
               if (hasNext) sel_q <= nextSel;
               state_q <= hasNext ? WAIT : (CSUM_EN ? CSUM : DONE);
            end
            CSUM: if (adv) state_q <= DONE;
            DONE: if (adv) begin
               evtCount_q <= evtCount_q + 16'd1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.m_tdata   = mData_q;
   assign bus.m_tvalid  = mValid_q;
   assign bus.m_tlast   = mLast_q;
   assign event_count_o = evtCount_q;
   assign timeout_o     = timeout_q;
   assign busy_o        = (state_q != IDLE);
endmodule
